int_seq: RTL and testbench

Interrupt and reset sequencer for the 6502 core. It sits directly upstream of the CPU microcode sequencer. It samples `RST`, `NMI`, `IRQ` and `SO`, decides at each opcode-fetch boundary whether a hardware interrupt is taken, and forces opcode `0x00` into IR when one is. During the service sequence it supplies the vector address, the pushed B-flag value and the reset write-inhibit.

---
 rtl/int_seq_pkg.sv | 36 +++
 rtl/int_seq_edge_det.sv | 22 ++
 rtl/int_seq.sv | 148 ++++++++++++++
 tb/tb_int_seq.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_seq_pkg.sv
// Shared encodings and default vectors for the 6502 interrupt/reset sequencer.
package int_seq_pkg;

    localparam int unsigned VEC_W  = 16;
    localparam int unsigned KIND_W = 2;

    typedef enum logic [KIND_W-1:0] {
        INT_NONE = 2'd0,
        INT_IRQ  = 2'd1,
        INT_NMI  = 2'd2,
        INT_RST  = 2'd3
    } int_kind_e;

    typedef enum logic [1:0] {
        ST_RESET   = 2'd0,
        ST_IDLE    = 2'd1,
        ST_SERVICE = 2'd2
    } state_e;

    localparam logic [VEC_W-1:0] DEF_RST_VEC = 16'hFFFC;
    localparam logic [VEC_W-1:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [VEC_W-1:0] DEF_IRQ_VEC = 16'hFFFE;

    // Vector low-byte address selected by an interrupt kind; NONE shares the IRQ/BRK vector.
    function automatic logic [VEC_W-1:0] kind_vec(input int_kind_e        kind,
                                                  input logic [VEC_W-1:0] rst_v,
                                                  input logic [VEC_W-1:0] nmi_v,
                                                  input logic [VEC_W-1:0] irq_v);
        case (kind)
            INT_RST: kind_vec = rst_v;
            INT_NMI: kind_vec = nmi_v;
            default: kind_vec = irq_v;
        endcase
    endfunction

endpackage

// File: rtl/int_seq_edge_det.sv
// Registered falling-edge detector; the sample register resets high so a pin held low
// through reset still produces one edge after release.
module int_seq_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic fall_c
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b1;
        end else begin
            q <= d;
        end
    end

    assign fall_c = q & ~d;

endmodule

// File: rtl/int_seq.sv
// Interrupt and reset sequencer: decides at opcode fetch whether RST/NMI/IRQ is serviced
// and supplies vector, pushed B flag and write-inhibit for the service sequence.
module int_seq
    import int_seq_pkg::*;
#(
    parameter logic [VEC_W-1:0] RST_VEC = DEF_RST_VEC,
    parameter logic [VEC_W-1:0] NMI_VEC = DEF_NMI_VEC,
    parameter logic [VEC_W-1:0] IRQ_VEC = DEF_IRQ_VEC
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              NMI,
    input  logic              IRQ,
    input  logic              SO,
    input  logic              sr_i,
    input  logic              fetch,
    input  logic              vec_fetch,
    output logic              force_brk,
    output logic [VEC_W-1:0]  vector,
    output logic [KIND_W-1:0] int_kind,
    output logic              b_flag,
    output logic              wr_inhibit,
    output logic              so_pulse
);

    state_e    state_q, state_d;
    int_kind_e kind_q, kind_d;
    int_kind_e take_c, eff_c;
    logic      nmi_latch, nmi_clr_c;
    logic      nmi_fall_c, so_fall_c;
    logic      irq_q;

    int_seq_edge_det u_nmi_edge (
        .clk    (clk),
        .rst_n  (RST),
        .d      (NMI),
        .fall_c (nmi_fall_c)
    );

    int_seq_edge_det u_so_edge (
        .clk    (clk),
        .rst_n  (RST),
        .d      (SO),
        .fall_c (so_fall_c)
    );

    // Candidate at a fetch boundary, and the kind in service after a possible NMI hijack.
    always_comb begin
        take_c = INT_NONE;
        if (nmi_latch) begin
            take_c = INT_NMI;
        end else if (!irq_q && !sr_i) begin
            take_c = INT_IRQ;
        end
        eff_c = kind_q;
        if (kind_q == INT_IRQ && nmi_latch) begin
            eff_c = INT_NMI;
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // A new NMI edge in the clearing cycle wins so that NMI stays pending.
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            kind_q    <= INT_RST;
            nmi_latch <= 1'b0;
            irq_q     <= 1'b1;
            so_pulse  <= 1'b0;
        end else begin
            kind_q    <= kind_d;
            nmi_latch <= nmi_fall_c | (nmi_latch & ~nmi_clr_c);
            irq_q     <= IRQ;
            so_pulse  <= so_fall_c;
        end
    end

    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        nmi_clr_c = 1'b0;
        case (state_q)
            ST_RESET: begin
                if (fetch) begin
                    state_d = ST_SERVICE;
                    kind_d  = INT_RST;
                end
            end
            ST_IDLE: begin
                if (fetch && take_c != INT_NONE) begin
                    state_d = ST_SERVICE;
                    kind_d  = take_c;
                end
                // A software BRK hijacked by NMI consumes the NMI at its vector read.
                if (vec_fetch && nmi_latch) begin
                    nmi_clr_c = 1'b1;
                end
            end
            ST_SERVICE: begin
                kind_d = eff_c;
                if (vec_fetch) begin
                    state_d   = ST_IDLE;
                    nmi_clr_c = (eff_c == INT_NMI);
                end
            end
            default: state_d = ST_RESET;
        endcase
    end

    always_comb begin
        force_brk  = 1'b0;
        int_kind   = INT_NONE;
        vector     = IRQ_VEC;
        b_flag     = 1'b0;
        wr_inhibit = 1'b0;
        case (state_q)
            ST_RESET: begin
                force_brk  = fetch & RST;
                int_kind   = INT_RST;
                vector     = RST_VEC;
                wr_inhibit = 1'b1;
            end
            ST_IDLE: begin
                if (fetch && take_c != INT_NONE) begin
                    force_brk = 1'b1;
                    int_kind  = take_c;
                    vector    = kind_vec(take_c, RST_VEC, NMI_VEC, IRQ_VEC);
                end else begin
                    b_flag = 1'b1;
                    vector = nmi_latch ? NMI_VEC : IRQ_VEC;
                end
            end
            ST_SERVICE: begin
                int_kind   = eff_c;
                vector     = kind_vec(eff_c, RST_VEC, NMI_VEC, IRQ_VEC);
                wr_inhibit = (eff_c == INT_RST);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_seq.sv
// Scoreboard bench for int_seq: a CPU-like driver with a pin-history reference model
// pushes expectations; a negedge monitor pops them on fetch/vec_fetch and so_pulse.
module tb_int_seq;

    localparam logic [15:0] V_RST = 16'hFFFC;
    localparam logic [15:0] V_NMI = 16'hFFFA;
    localparam logic [15:0] V_IRQ = 16'hFFFE;
    localparam int MAXC = 8192;

    typedef struct {
        int          cyc;
        logic        frc;
        logic [1:0]  kind;
        logic [15:0] vec;
        logic        b;
        logic        wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        RST, NMI, IRQ, SO, sr_i, fetch, vec_fetch;
    logic        force_brk, b_flag, wr_inhibit, so_pulse;
    logic [15:0] vector;
    logic [1:0]  int_kind;

    int_seq dut (
        .clk        (clk),
        .RST        (RST),
        .NMI        (NMI),
        .IRQ        (IRQ),
        .SO         (SO),
        .sr_i       (sr_i),
        .fetch      (fetch),
        .vec_fetch  (vec_fetch),
        .force_brk  (force_brk),
        .vector     (vector),
        .int_kind   (int_kind),
        .b_flag     (b_flag),
        .wr_inhibit (wr_inhibit),
        .so_pulse   (so_pulse)
    );

    initial forever #5 clk = ~clk;

    exp_t exp_q[$];
    int   so_q[$];
    int   tests = 0;
    int   fails = 0;
    logic nmi_pin[MAXC];
    logic irq_pin[MAXC];
    logic so_pin[MAXC];
    int   cyc = 0;
    int   c0 = 0;
    int   consumed = 0;
    int   mode = 0;        // 0 reset, 1 idle, 2 service
    int   svc_kind = 0;
    bit   took;
    bit   rand_en = 1'b0;
    logic n_nmi = 1'b1, n_irq = 1'b1, n_so = 1'b1, n_sr = 1'b1;
    exp_t mon_e;

    function automatic bit nmi_edge(input int j);
        if (j < c0) return 1'b0;
        return ((j == c0) ? 1'b1 : nmi_pin[j-1]) && !nmi_pin[j];
    endfunction

    // NMI is pending at cycle c if an unconsumed falling edge happened in an earlier cycle.
    function automatic bit nmi_pending(input int c);
        for (int j = consumed; j < c; j++) begin
            if (nmi_edge(j)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic irq_seen(input int c);
        return (c > c0) ? irq_pin[c-1] : 1'b1;
    endfunction

    function automatic logic [15:0] vec_of(input int k);
        case (k)
            3:       return V_RST;
            2:       return V_NMI;
            default: return V_IRQ;
        endcase
    endfunction

    function automatic exp_t mk(input int c, input logic f, input logic [1:0] k,
                                input logic [15:0] v, input logic b, input logic w);
        exp_t e;
        e.cyc = c; e.frc = f; e.kind = k; e.vec = v; e.b = b; e.wr = w;
        return e;
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic model_step(input bit f, input bit vf);
        int   c;
        bit   pend;
        int   tk;
        int   eff;
        exp_t e;
        c    = cyc;
        pend = nmi_pending(c);
        if (!(f || vf)) return;
        case (mode)
            0: begin
                e = mk(c, 1'b1, 2'd3, V_RST, 1'b0, 1'b1);
                mode = 2; svc_kind = 3; took = 1'b1;
            end
            1: begin
                if (f) begin
                    tk = pend ? 2 : ((irq_seen(c) == 1'b0 && !sr_i) ? 1 : 0);
                    if (tk != 0) begin
                        e = mk(c, 1'b1, 2'(tk), vec_of(tk), 1'b0, 1'b0);
                        mode = 2; svc_kind = tk; took = 1'b1;
                    end else begin
                        e = mk(c, 1'b0, 2'd0, V_IRQ, 1'b1, 1'b0);
                    end
                end else begin
                    e = mk(c, 1'b0, 2'd0, pend ? V_NMI : V_IRQ, 1'b1, 1'b0);
                    if (pend) consumed = c;
                end
            end
            default: begin
                eff = (svc_kind == 1 && pend) ? 2 : svc_kind;
                svc_kind = eff;
                e = mk(c, 1'b0, 2'(eff), vec_of(eff), 1'b0, eff == 3);
                if (vf) begin
                    if (eff == 2) consumed = c;
                    mode = 1;
                end
            end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic cycle(input bit f, input bit vf, input bit rel);
        @(posedge clk);
        #1;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles expected < %0d", cyc, MAXC);
            $fatal(1);
        end
        if (rand_en) begin
            if ($urandom_range(11) == 0) n_nmi = ~n_nmi;
            if ($urandom_range(9) == 0)  n_irq = ~n_irq;
            if ($urandom_range(7) == 0)  n_so  = ~n_so;
            if ($urandom_range(9) == 0)  n_sr  = ~n_sr;
        end
        if (rel) begin
            RST = 1'b1; c0 = cyc; consumed = cyc; mode = 0;
        end
        NMI = n_nmi; IRQ = n_irq; SO = n_so; sr_i = n_sr;
        fetch = f; vec_fetch = vf;
        nmi_pin[cyc] = n_nmi; irq_pin[cyc] = n_irq; so_pin[cyc] = n_so;
        if (cyc >= c0 && ((cyc == c0) ? 1'b1 : so_pin[cyc-1]) && !n_so) so_q.push_back(cyc + 1);
        model_step(f, vf);
    endtask

    // One instruction: opcode fetch, then either a 6-cycle service (vector read at cycle 5),
    // a software BRK, or a short ordinary instruction.
    task automatic run_instr(input int drop_k, input bit brk);
        took = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        if (took) begin
            for (int k = 1; k <= 6; k++) begin
                if (k == drop_k) n_nmi = 1'b0;
                cycle(rand_en && k == 2 && $urandom_range(3) == 0, k == 5, 1'b0);
            end
        end else if (brk) begin
            for (int k = 1; k <= 5; k++) cycle(1'b0, k == 5, 1'b0);
        end else begin
            repeat (1 + $urandom_range(2)) cycle(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_force"}, 16'(force_brk), 16'h0);
        check({tag, "_vector"}, vector, V_RST);
        check({tag, "_kind"}, 16'(int_kind), 16'h3);
        check({tag, "_bflag"}, 16'(b_flag), 16'h0);
        check({tag, "_wrinh"}, 16'(wr_inhibit), 16'h1);
        check({tag, "_so"}, 16'(so_pulse), 16'h0);
    endtask

    always @(negedge clk) begin
        if (RST === 1'b1) begin
            if (fetch || vec_fetch) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL strobe: got unexpected strobe at cycle %0d expected none", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (force_brk !== mon_e.frc || int_kind !== mon_e.kind || vector !== mon_e.vec ||
                        b_flag !== mon_e.b || wr_inhibit !== mon_e.wr) begin
                        fails++;
                        $display("FAIL strobe cyc %0d: got force=%b kind=%0d vec=%h b=%b wr=%b expected force=%b kind=%0d vec=%h b=%b wr=%b",
                                 mon_e.cyc, force_brk, int_kind, vector, b_flag, wr_inhibit,
                                 mon_e.frc, mon_e.kind, mon_e.vec, mon_e.b, mon_e.wr);
                    end
                end
            end
            if (so_pulse === 1'b1) begin
                tests++;
                if (so_q.size() == 0) begin
                    fails++;
                    $display("FAIL so_pulse: got pulse at cycle %0d expected none", cyc);
                end else if (so_q[0] != cyc) begin
                    fails++;
                    $display("FAIL so_pulse: got pulse at cycle %0d expected cycle %0d", cyc, so_q[0]);
                    void'(so_q.pop_front());
                end else begin
                    void'(so_q.pop_front());
                end
            end
        end
    end

    initial begin
        RST = 1'b0; NMI = 1'b1; IRQ = 1'b1; SO = 1'b1; sr_i = 1'b1;
        fetch = 1'b0; vec_fetch = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        fetch = 1'b1;
        #1;
        check("reset_fetch_force", 16'(force_brk), 16'h0);
        fetch = 1'b0;

        // reset release, fetch in cycle 3 starts the reset service
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0);
        run_instr(0, 1'b0);

        // IRQ taken with I clear, ignored with I set
        n_irq = 1'b0; n_sr = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0);
        n_sr = 1'b1;
        run_instr(0, 1'b0);
        n_irq = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);

        // NMI hijacks an IRQ service two cycles before the vector read
        n_irq = 1'b0; n_sr = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(3, 1'b0);
        n_irq = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0);

        // NMI held low over many fetches gives one service; a re-edge gives another
        n_nmi = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        n_nmi = 1'b0;
        repeat (14) run_instr(0, 1'b0);
        n_nmi = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        n_nmi = 1'b0;
        run_instr(0, 1'b0);
        run_instr(0, 1'b0);

        // NMI edge exactly in the vector-read cycle of an NMI service stays pending
        n_nmi = 1'b1;
        cycle(1'b0, 1'b0, 1'b0);
        n_nmi = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        n_nmi = 1'b1;
        run_instr(5, 1'b0);
        run_instr(0, 1'b0);
        run_instr(0, 1'b0);
        n_nmi = 1'b1;

        // software BRK, then BRK hijacked by NMI
        run_instr(0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        took = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        n_nmi = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0);
        n_nmi = 1'b1;

        // SO falling edge
        n_so = 1'b0;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        n_so = 1'b1;
        repeat (2) cycle(1'b0, 1'b0, 1'b0);

        // reset asserted mid-service takes effect without a clock edge
        n_irq = 1'b0; n_sr = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        took = 1'b0;
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        RST = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        n_irq = 1'b1; n_sr = 1'b1;
        repeat (2) @(posedge clk);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0);
        run_instr(0, 1'b0);

        // randomized traffic
        rand_en = 1'b1;
        repeat (300) run_instr(0, $urandom_range(7) == 0);
        rand_en = 1'b0;
        n_so = 1'b1;
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("exp_queue_left", 16'(exp_q.size()), 16'h0);
        check("so_queue_left", 16'(so_q.size()), 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
